// File: rtl/fft_iter_addr_gen.sv
// ============================================================================
// Module      : fft_iter_addr_gen
// Description : In-place radix-2 DIT read/twiddle address decode with a
//               show-ahead FIFO that replays read pairs as write-back pairs.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fft_iter_addr_gen #(
  parameter int LAYERS      = 5,
  parameter int BUTTERFLYES = 16,
  parameter int LayWL       = 3,
  parameter int ButtWL      = 4,
  parameter int FIFO_DEPTH  = 8
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              EN,
  input  logic              ADDR_RST,
  input  logic              ADDR_EN,
  input  logic              LAY_EN,
  input  logic              Wr,
  output logic [LAYERS-1:0] RD_ADDR_A,
  output logic [LAYERS-1:0] RD_ADDR_B,
  output logic [ButtWL-1:0] TW_ADDR,
  output logic [LAYERS-1:0] WR_ADDR_A,
  output logic [LAYERS-1:0] WR_ADDR_B,
  output logic              WR_VALID,
  output logic [LayWL-1:0]  LAY_CNT,
  output logic [ButtWL-1:0] BUT_CNT,
  output logic              LAST_BUT,
  output logic              LAST_LAY,
  output logic              ERR
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam logic [AW:0]       C_FULL     = (AW+1)'(FIFO_DEPTH);
  localparam logic [ButtWL-1:0] C_LAST_BUT = ButtWL'(BUTTERFLYES-1);
  localparam logic [LayWL-1:0]  C_LAST_LAY = LayWL'(LAYERS-1);

  logic [LayWL-1:0]    r_lay_cnt;
  logic [ButtWL-1:0]   r_but_cnt;
  logic [AW-1:0]       r_wptr;
  logic [AW-1:0]       r_rptr;
  logic [AW:0]         r_count;
  logic                r_err;
  logic [2*LAYERS-1:0] r_last;
  logic [2*LAYERS-1:0] r_mem [FIFO_DEPTH];

  logic [LAYERS-1:0]   w_b_ext;
  logic [LAYERS-1:0]   w_mask;
  logic [LAYERS-1:0]   w_rd_a;
  logic [LAYERS-1:0]   w_rd_b;
  logic [LayWL-1:0]    w_tw_sh;
  logic [LAYERS-1:0]   w_tw_full;
  logic [2*LAYERS-1:0] w_head;
  logic                w_run;
  logic                w_empty;
  logic                w_full;
  logic                w_pop;
  logic                w_push;
  logic                w_err_ev;

  // Insert a 0 (A) or 1 (B) at bit position LAY_CNT of the butterfly index.
  assign w_b_ext   = LAYERS'(r_but_cnt);
  assign w_mask    = (LAYERS'(1) << r_lay_cnt) - LAYERS'(1);
  assign w_rd_a    = ((w_b_ext & ~w_mask) << 1) | (w_b_ext & w_mask);
  assign w_rd_b    = w_rd_a | (LAYERS'(1) << r_lay_cnt);
  assign w_tw_sh   = C_LAST_LAY - r_lay_cnt;
  assign w_tw_full = (w_b_ext & w_mask) << w_tw_sh;

  assign w_run    = EN && !ADDR_RST;
  assign w_empty  = (r_count == '0);
  assign w_full   = (r_count == C_FULL);
  assign w_pop    = w_run && Wr && !w_empty;
  assign w_push   = w_run && ADDR_EN && (!w_full || w_pop);
  assign w_err_ev = w_run && ((ADDR_EN && w_full && !Wr) || (Wr && w_empty));

  // When drained, the outputs keep showing the most recently popped pair.
  assign w_head = w_empty ? r_last : r_mem[r_rptr];

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      r_lay_cnt <= '0;
      r_but_cnt <= '0;
      r_wptr    <= '0;
      r_rptr    <= '0;
      r_count   <= '0;
      r_err     <= 1'b0;
      r_last    <= '0;
    end else if (EN) begin
      if (ADDR_RST) begin
        r_lay_cnt <= '0;
        r_but_cnt <= '0;
        r_wptr    <= '0;
        r_rptr    <= '0;
        r_count   <= '0;
        r_err     <= 1'b0;
        r_last    <= '0;
      end else begin
        if (ADDR_EN) begin
          r_but_cnt <= (r_but_cnt == C_LAST_BUT) ? '0 : r_but_cnt + 1'b1;
        end
        if (LAY_EN) begin
          r_lay_cnt <= (r_lay_cnt == C_LAST_LAY) ? '0 : r_lay_cnt + 1'b1;
        end
        if (w_push) begin
          r_wptr <= r_wptr + 1'b1;
        end
        if (w_pop) begin
          r_rptr <= r_rptr + 1'b1;
          r_last <= r_mem[r_rptr];
        end
        case ({w_push, w_pop})
          2'b10:   r_count <= r_count + 1'b1;
          2'b01:   r_count <= r_count - 1'b1;
          default: r_count <= r_count;
        endcase
        if (w_err_ev) begin
          r_err <= 1'b1;
        end
      end
    end
  end

  // Storage needs no reset: entries are only visible while r_count covers them.
  always_ff @(posedge CLK) begin
    if (w_push) begin
      r_mem[r_wptr] <= {w_rd_a, w_rd_b};
    end
  end

  assign RD_ADDR_A = w_rd_a;
  assign RD_ADDR_B = w_rd_b;
  assign TW_ADDR   = w_tw_full[ButtWL-1:0];
  assign WR_ADDR_A = w_head[2*LAYERS-1:LAYERS];
  assign WR_ADDR_B = w_head[LAYERS-1:0];
  assign WR_VALID  = !w_empty;
  assign LAY_CNT   = r_lay_cnt;
  assign BUT_CNT   = r_but_cnt;
  assign LAST_BUT  = (r_but_cnt == C_LAST_BUT);
  assign LAST_LAY  = (r_lay_cnt == C_LAST_LAY);
  assign ERR       = r_err;

endmodule

`default_nettype wire

// File: tb/tb_fft_iter_addr_gen.sv
// Testbench for fft_iter_addr_gen: directed table, hand sequences and a
// randomized run against an arithmetic/queue reference model.
`default_nettype none

module tb_fft_iter_addr_gen;

  localparam int LAYERS = 3;
  localparam int BUTT   = 4;
  localparam int LAYWL  = 2;
  localparam int BUTTWL = 2;
  localparam int DEPTH  = 4;

  logic CLK = 1'b0;
  logic RST, EN, ADDR_RST, ADDR_EN, LAY_EN, Wr;
  logic [LAYERS-1:0] RD_ADDR_A, RD_ADDR_B, WR_ADDR_A, WR_ADDR_B;
  logic [BUTTWL-1:0] TW_ADDR, BUT_CNT;
  logic [LAYWL-1:0]  LAY_CNT;
  logic WR_VALID, LAST_BUT, LAST_LAY, ERR;

  fft_iter_addr_gen #(
    .LAYERS(LAYERS), .BUTTERFLYES(BUTT), .LayWL(LAYWL),
    .ButtWL(BUTTWL), .FIFO_DEPTH(DEPTH)
  ) dut (
    .CLK(CLK), .RST(RST), .EN(EN), .ADDR_RST(ADDR_RST), .ADDR_EN(ADDR_EN),
    .LAY_EN(LAY_EN), .Wr(Wr), .RD_ADDR_A(RD_ADDR_A), .RD_ADDR_B(RD_ADDR_B),
    .TW_ADDR(TW_ADDR), .WR_ADDR_A(WR_ADDR_A), .WR_ADDR_B(WR_ADDR_B),
    .WR_VALID(WR_VALID), .LAY_CNT(LAY_CNT), .BUT_CNT(BUT_CNT),
    .LAST_BUT(LAST_BUT), .LAST_LAY(LAST_LAY), .ERR(ERR)
  );

  always #5 CLK = ~CLK;

  int checks = 0;
  int failures = 0;

  // Reference model state
  int m_lay, m_but, m_last_a, m_last_b;
  int m_qa[$];
  int m_qb[$];
  bit m_err;

  function automatic int f_rda(int l, int b);
    return ((b >> l) << (l + 1)) + (b % (1 << l));
  endfunction

  function automatic int f_tw(int l, int b);
    return ((b % (1 << l)) << (LAYERS - 1 - l)) % (1 << BUTTWL);
  endfunction

  task automatic model_reset();
    m_lay = 0; m_but = 0; m_err = 0; m_last_a = 0; m_last_b = 0;
    m_qa.delete(); m_qb.delete();
  endtask

  task automatic model_step(input bit en, arst, aen, len, wr);
    int pa, pb;
    if (!en) return;
    if (arst) begin
      model_reset();
      return;
    end
    pa = f_rda(m_lay, m_but);
    pb = pa + (1 << m_lay);
    if (wr) begin
      if (m_qa.size() == 0) m_err = 1;
      else begin
        m_last_a = m_qa.pop_front();
        m_last_b = m_qb.pop_front();
      end
    end
    if (aen) begin
      if (m_qa.size() < DEPTH) begin
        m_qa.push_back(pa);
        m_qb.push_back(pb);
      end else m_err = 1;
      m_but = (m_but + 1) % BUTT;
    end
    if (len) m_lay = (m_lay + 1) % LAYERS;
  endtask

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic check_model(input string tag);
    int ea, eb;
    ea = f_rda(m_lay, m_but);
    eb = ea + (1 << m_lay);
    chk({tag, " RD_ADDR_A"}, int'(RD_ADDR_A), ea);
    chk({tag, " RD_ADDR_B"}, int'(RD_ADDR_B), eb);
    chk({tag, " TW_ADDR"},   int'(TW_ADDR), f_tw(m_lay, m_but));
    chk({tag, " LAY_CNT"},   int'(LAY_CNT), m_lay);
    chk({tag, " BUT_CNT"},   int'(BUT_CNT), m_but);
    chk({tag, " LAST_BUT"},  int'(LAST_BUT), int'(m_but == BUTT - 1));
    chk({tag, " LAST_LAY"},  int'(LAST_LAY), int'(m_lay == LAYERS - 1));
    chk({tag, " ERR"},       int'(ERR), int'(m_err));
    chk({tag, " WR_VALID"},  int'(WR_VALID), int'(m_qa.size() != 0));
    chk({tag, " WR_ADDR_A"}, int'(WR_ADDR_A), (m_qa.size() != 0) ? m_qa[0] : m_last_a);
    chk({tag, " WR_ADDR_B"}, int'(WR_ADDR_B), (m_qb.size() != 0) ? m_qb[0] : m_last_b);
  endtask

  // One clock with the given strobes; model and DUT are compared 1 ns after the edge.
  task automatic cyc(input bit en, arst, aen, len, wr);
    EN = en; ADDR_RST = arst; ADDR_EN = aen; LAY_EN = len; Wr = wr;
    @(posedge CLK);
    model_step(en, arst, aen, len, wr);
    #1;
    EN = 1'b1; ADDR_RST = 1'b0; ADDR_EN = 1'b0; LAY_EN = 1'b0; Wr = 1'b0;
    check_model("cyc");
  endtask

  task automatic expect_head(input string name, input int a, input int b);
    chk({name, " head A"}, int'(WR_ADDR_A), a);
    chk({name, " head B"}, int'(WR_ADDR_B), b);
  endtask

  typedef struct {
    bit aen, len, wr;
    int a, b, tw, lay, but;
    bit lb, ll;
  } vec_t;

  function automatic vec_t mk(bit aen, bit len, bit wr, int a, int b, int tw,
                              int lay, int but, bit lb, bit ll);
    vec_t v;
    v.aen = aen; v.len = len; v.wr = wr; v.a = a; v.b = b; v.tw = tw;
    v.lay = lay; v.but = but; v.lb = lb; v.ll = ll;
    return v;
  endfunction

  vec_t tbl[16];

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Expected read side shown BEFORE each record's strobes are applied.
    tbl[0]  = mk(1, 0, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[1]  = mk(1, 0, 1, 2, 3, 0, 0, 1, 0, 0);
    tbl[2]  = mk(1, 0, 1, 4, 5, 0, 0, 2, 0, 0);
    tbl[3]  = mk(1, 0, 1, 6, 7, 0, 0, 3, 1, 0);
    tbl[4]  = mk(0, 1, 0, 0, 1, 0, 0, 0, 0, 0);
    tbl[5]  = mk(1, 0, 1, 0, 2, 0, 1, 0, 0, 0);
    tbl[6]  = mk(1, 0, 1, 1, 3, 2, 1, 1, 0, 0);
    tbl[7]  = mk(1, 0, 1, 4, 6, 0, 1, 2, 0, 0);
    tbl[8]  = mk(1, 0, 1, 5, 7, 2, 1, 3, 1, 0);
    tbl[9]  = mk(0, 1, 0, 0, 2, 0, 1, 0, 0, 0);
    tbl[10] = mk(1, 0, 1, 0, 4, 0, 2, 0, 0, 1);
    tbl[11] = mk(1, 0, 1, 1, 5, 1, 2, 1, 0, 1);
    tbl[12] = mk(1, 0, 1, 2, 6, 2, 2, 2, 0, 1);
    tbl[13] = mk(1, 0, 1, 3, 7, 3, 2, 3, 1, 1);
    tbl[14] = mk(0, 1, 0, 0, 4, 0, 2, 0, 0, 1);
    tbl[15] = mk(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);

    RST = 1'b0; EN = 1'b0; ADDR_RST = 1'b0; ADDR_EN = 1'b0; LAY_EN = 1'b0; Wr = 1'b0;
    model_reset();
    repeat (2) @(posedge CLK);
    #1;
    RST = 1'b1; EN = 1'b1;
    chk("reset RD_ADDR_A", int'(RD_ADDR_A), 0);
    chk("reset RD_ADDR_B", int'(RD_ADDR_B), 1);
    chk("reset WR_VALID", int'(WR_VALID), 0);
    chk("reset ERR", int'(ERR), 0);
    check_model("reset");

    // Address sequences through all three layers
    foreach (tbl[i]) begin
      chk($sformatf("tbl%0d RD_A", i), int'(RD_ADDR_A), tbl[i].a);
      chk($sformatf("tbl%0d RD_B", i), int'(RD_ADDR_B), tbl[i].b);
      chk($sformatf("tbl%0d TW", i), int'(TW_ADDR), tbl[i].tw);
      chk($sformatf("tbl%0d LAY", i), int'(LAY_CNT), tbl[i].lay);
      chk($sformatf("tbl%0d BUT", i), int'(BUT_CNT), tbl[i].but);
      chk($sformatf("tbl%0d LAST_BUT", i), int'(LAST_BUT), int'(tbl[i].lb));
      chk($sformatf("tbl%0d LAST_LAY", i), int'(LAST_LAY), int'(tbl[i].ll));
      cyc(1, 0, tbl[i].aen, tbl[i].len, tbl[i].wr);
    end

    // Delayed write-back in layer 1
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (3) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 0, 0, 0);
    expect_head("wb0", 0, 2); cyc(1, 0, 0, 0, 1);
    expect_head("wb1", 1, 3); cyc(1, 0, 0, 0, 1);
    expect_head("wb2", 4, 6); cyc(1, 0, 0, 0, 1);
    chk("wb drained WR_VALID", int'(WR_VALID), 0);
    chk("wb drained ERR", int'(ERR), 0);
    expect_head("wb hold", 4, 6);

    // Push+pop while full
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    repeat (4) cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 1);
    expect_head("full0", 1, 3); cyc(1, 0, 0, 0, 1);
    expect_head("full1", 4, 6); cyc(1, 0, 0, 0, 1);
    expect_head("full2", 5, 7); cyc(1, 0, 0, 0, 1);
    expect_head("full3", 0, 2); cyc(1, 0, 0, 0, 1);
    chk("full ERR", int'(ERR), 0);
    chk("full drained WR_VALID", int'(WR_VALID), 0);

    // Overflow: the fifth pair is dropped
    cyc(1, 1, 0, 0, 0);
    repeat (5) cyc(1, 0, 1, 0, 0);
    chk("ovf ERR", int'(ERR), 1);
    expect_head("ovf0", 0, 1); cyc(1, 0, 0, 0, 1);
    expect_head("ovf1", 2, 3); cyc(1, 0, 0, 0, 1);
    expect_head("ovf2", 4, 5); cyc(1, 0, 0, 0, 1);
    expect_head("ovf3", 6, 7); cyc(1, 0, 0, 0, 1);
    chk("ovf drained WR_VALID", int'(WR_VALID), 0);

    // Underflow, then ADDR_RST clears
    cyc(1, 1, 0, 0, 0);
    chk("arst ERR", int'(ERR), 0);
    cyc(1, 0, 0, 0, 1);
    chk("udf ERR", int'(ERR), 1);
    chk("udf WR_VALID", int'(WR_VALID), 0);
    cyc(1, 1, 0, 0, 0);
    chk("arst2 ERR", int'(ERR), 0);
    chk("arst2 BUT_CNT", int'(BUT_CNT), 0);
    chk("arst2 LAY_CNT", int'(LAY_CNT), 0);

    // EN gating
    cyc(1, 0, 1, 0, 0);
    cyc(0, 1, 1, 1, 1);
    cyc(0, 0, 1, 1, 1);
    chk("en0 BUT_CNT", int'(BUT_CNT), 1);
    chk("en0 WR_VALID", int'(WR_VALID), 1);
    expect_head("en0", 0, 1);

    // Asynchronous reset mid-layer 2 with two entries queued
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 0, 1, 0);
    cyc(1, 0, 1, 0, 0);
    cyc(1, 0, 1, 0, 0);
    #2;
    RST = 1'b0;
    #1;
    model_reset();
    chk("async RD_ADDR_B", int'(RD_ADDR_B), 1);
    chk("async LAY_CNT", int'(LAY_CNT), 0);
    chk("async WR_VALID", int'(WR_VALID), 0);
    check_model("async");
    @(negedge CLK);
    RST = 1'b1;

    // Randomized run against the model
    for (int n = 0; n < 400; n++) begin
      cyc($urandom_range(0, 9) != 0, $urandom_range(0, 39) == 0,
          1'($urandom_range(0, 1)), $urandom_range(0, 7) == 0,
          1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/fft_iter_addr_gen.md
Name: fft_iter_addr_gen

Overview:
- Consumer of the iterative-FFT control unit strobes (ADDR_RST, ADDR_EN, LAY_EN, Wr).
- Turns those strobes into in-place radix-2 DIT read address pairs, the twiddle ROM address, and the matching write-back address pairs.
- Write-back addresses come from an internal address FIFO. This hides the butterfly latency (2..5 cycles) between read and write.
- Sits between the control unit and the data RAM / twiddle ROM of the iterative FFT core.

Parameters:
- LAYERS, 5, number of FFT stages; the transform size is N = 2^LAYERS.
- BUTTERFLYES, 16, butterflies per stage; must equal N/2.
- LayWL, 3, width of the layer counter; must satisfy 2^LayWL >= LAYERS.
- ButtWL, 4, width of the butterfly counter; must equal LAYERS-1.
- FIFO_DEPTH, 8, depth of the write-address FIFO; power of 2, at least 2 and at least the butterfly cycle count.

Ports:
- CLK  in  1  clock; all state updates on the rising edge.
- RST  in  1  asynchronous active-low reset.
- EN  in  1  global enable; when 0, all state is frozen.
- ADDR_RST  in  1  synchronous restart of counters and FIFO.
- ADDR_EN  in  1  advance to next butterfly; pushes the current read pair into the FIFO.
- LAY_EN  in  1  advance to next layer.
- Wr  in  1  write-back of one butterfly result; pops the FIFO.
- RD_ADDR_A  out  LAYERS  read address, even (top) input of the butterfly.
- RD_ADDR_B  out  LAYERS  read address, odd (bottom) input of the butterfly.
- TW_ADDR  out  ButtWL  twiddle ROM index.
- WR_ADDR_A  out  LAYERS  write address, top output (FIFO head).
- WR_ADDR_B  out  LAYERS  write address, bottom output (FIFO head).
- WR_VALID  out  1  FIFO not empty.
- LAY_CNT  out  LayWL  current layer.
- BUT_CNT  out  ButtWL  current butterfly.
- LAST_BUT  out  1  BUT_CNT == BUTTERFLYES-1.
- LAST_LAY  out  1  LAY_CNT == LAYERS-1.
- ERR  out  1  sticky FIFO overflow/underflow flag.

Behaviour:
- Reset (RST=0, asynchronous): LAY_CNT=0, BUT_CNT=0, FIFO empty, ERR=0.
  - All outputs are therefore 0, except RD_ADDR_B = 1 (the decode of layer 0, butterfly 0).
  - WR_ADDR_A/B = 0 and WR_VALID = 0.
- EN=0: no register changes; every input strobe is ignored.
- Priority when EN=1: ADDR_RST > (ADDR_EN, LAY_EN, Wr).
  - ADDR_RST sets LAY_CNT=0, BUT_CNT=0, flushes the FIFO and clears ERR.
  - All other strobes in that cycle are ignored.
- ADDR_EN:
  - BUT_CNT increments and wraps from BUTTERFLYES-1 to 0.
  - The pre-increment {RD_ADDR_A, RD_ADDR_B} is pushed into the FIFO.
- LAY_EN:
  - LAY_CNT increments and wraps from LAYERS-1 to 0.
  - It is independent of BUT_CNT.
  - If LAY_EN and ADDR_EN fire in the same cycle, both apply, and the pushed pair uses the pre-update layer and butterfly.
- Read decode: combinational from the counter registers, so it reflects the new counters one cycle after the strobe. With l = LAY_CNT and b = BUT_CNT:
  - RD_ADDR_A = b with a 0 inserted at bit position l, i.e. {b[ButtWL-1:l], 0, b[l-1:0]}.
  - RD_ADDR_B = the same with a 1 inserted at bit l; equivalently RD_ADDR_A + 2^l.
  - TW_ADDR = (b mod 2^l) << (LAYERS-1-l), truncated to ButtWL bits.
- FIFO behaviour:
  - Show-ahead: WR_ADDR_A/B always present the head entry; they hold their last value when the FIFO is empty.
  - Wr pops one entry.
  - Push and pop in the same cycle are legal at any occupancy, including full; count is unchanged and the data stays ordered.
- Error cases (ERR is set sticky; it clears only on RST or ADDR_RST):
  - Push while full without a pop: the push is dropped.
  - Wr while empty (including a simultaneous push into an empty FIFO): the pop is ignored. The push still happens.
- LAST_BUT and LAST_LAY: combinational compares on the counters.
- Reset asserted mid-transform: immediate return to the reset state. No partial entries survive.

Test Plan:
All scenarios use LAYERS=3, BUTTERFLYES=4, ButtWL=2, LayWL=2, FIFO_DEPTH=4 unless stated.
- Reset then 4x ADDR_EN in layer 0 -> (A,B) = (0,1), (2,3), (4,5), (6,7); TW = 0,0,0,0; LAST_BUT high on the 4th pair; BUT_CNT wraps to 0.
- LAY_EN then 4x ADDR_EN -> pairs (0,2), (1,3), (4,6), (5,7); TW = 0,2,0,2.
- Second LAY_EN -> pairs (0,4), (1,5), (2,6), (3,7); TW = 0,1,2,3; LAST_LAY=1. A further LAY_EN makes LAY_CNT=0.
- Wr pattern, layer 1:
  - 3x ADDR_EN, then Wr delayed 3 cycles per push -> WR_ADDR pairs (0,2), (1,3), (4,6) in order; WR_VALID deasserts after the last pop; ERR=0.
  - Same-cycle push+pop while full keeps count 4 and the order intact.
- Error injection:
  - 5 pushes with no pop -> ERR=1; the 5th pair (layer 0, butterfly 0) is absent from the pop sequence.
  - Wr on empty -> ERR=1, WR_VALID stays 0.
  - Then ADDR_RST -> ERR=0, counters 0.
- EN and reset gating:
  - EN=0 with ADDR_EN/LAY_EN/Wr pulsed -> no counter or FIFO change.
  - RST pulled low mid-layer 2 with 2 FIFO entries -> all outputs return to reset values asynchronously, before the next CLK edge.
